// File: rtl/alu_result_commit.sv
// Commit stage behind the ALU: holds the Z/V/N flag register, resolves B/BR branches and
// presents write-back data to the register file through a single valid/ready slot.
module alu_result_commit #(
   parameter int DW = 16,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          ex_valid,
   output logic          ex_ready,
   input  logic [3:0]    ex_opcode,
   input  logic [2:0]    ex_cond,
   input  logic [8:0]    ex_imm9,
   input  logic [DW-1:0] ex_in1,
   input  logic [DW-1:0] ex_in2,
   input  logic [DW-1:0] ex_alu_out,
   input  logic [DW-1:0] ex_pc_plus2,
   input  logic [RW-1:0] ex_rd,
   output logic          wb_valid,
   input  logic          wb_ready,
   output logic          wb_we,
   output logic [RW-1:0] wb_rd,
   output logic [DW-1:0] wb_data,
   output logic          br_taken,
   output logic [DW-1:0] br_target,
   output logic [2:0]    flags,
   output logic          halted
);

   localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_XOR = 4'b0010,
                          OP_SLL = 4'b0100, OP_SRA = 4'b0101, OP_ROR = 4'b0110,
                          OP_SW  = 4'b1001, OP_B   = 4'b1100, OP_BR  = 4'b1101,
                          OP_PCS = 4'b1110, OP_HLT = 4'b1111;

   localparam logic [0:0] ST_RUN = 1'b0, ST_HALTED = 1'b1;

   // Overflow of the true signed sum/difference: the 17-bit result leaves the 16-bit range
   // exactly when its top two bits differ.
   function automatic logic add_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic sub);
      logic [DW:0] ea, eb, s;
      ea = {a[DW-1], a};
      eb = {b[DW-1], b};
      s  = sub ? (ea - eb) : (ea + eb);
      return s[DW] ^ s[DW-1];
   endfunction

   // flag vector is {Z,V,N}
   function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] f);
      logic res;
      case (cond)
         3'b000:  res = ~f[2];
         3'b001:  res = f[2];
         3'b010:  res = ~f[2] & ~f[0];
         3'b011:  res = f[0];
         3'b100:  res = f[2] | ~f[0];
         3'b101:  res = f[2] | f[0];
         3'b110:  res = f[1];
         3'b111:  res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   logic [0:0]    state_r;
   logic          wb_valid_r, wb_we_r, br_taken_r;
   logic [RW-1:0] wb_rd_r;
   logic [DW-1:0] wb_data_r, br_target_r;
   logic [2:0]    flags_r;

   logic          accept_s, set_z_s, set_vn_s, we_s, is_br_s, take_s;
   logic [DW-1:0] data_s, target_s;

   assign ex_ready  = (state_r == ST_RUN) & (~wb_valid_r | wb_ready);
   assign accept_s  = ex_valid & ex_ready & ~flush;
   assign take_s    = accept_s & is_br_s & cond_met(ex_cond, flags_r);

   assign wb_valid  = wb_valid_r;
   assign wb_we     = wb_we_r;
   assign wb_rd     = wb_rd_r;
   assign wb_data   = wb_data_r;
   assign br_taken  = br_taken_r;
   assign br_target = br_target_r;
   assign flags     = flags_r;
   assign halted    = (state_r == ST_HALTED);

   // Opcode decode: flag scope, write enable, branch kind, write-back data and branch target.
   always_comb begin
      set_z_s  = 1'b0;
      set_vn_s = 1'b0;
      we_s     = 1'b1;
      is_br_s  = 1'b0;
      case (ex_opcode)
         OP_ADD, OP_SUB:         begin set_z_s = 1'b1; set_vn_s = 1'b1; end
         OP_XOR, OP_SLL,
         OP_SRA, OP_ROR:         set_z_s = 1'b1;
         OP_SW, OP_HLT:          we_s = 1'b0;
         OP_B, OP_BR:            begin we_s = 1'b0; is_br_s = 1'b1; end
         default:                we_s = 1'b1;
      endcase
      if (ex_opcode == OP_PCS) begin
         data_s = ex_pc_plus2;
      end else begin
         data_s = ex_alu_out;
      end
      if (ex_opcode == OP_BR) begin
         target_s = ex_in1;
      end else begin
         target_s = ex_pc_plus2 + {{(DW-10){ex_imm9[8]}}, ex_imm9, 1'b0};
      end
   end

   // Write-back slot; flush empties it ahead of any accept or drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_r <= 1'b0;
         wb_we_r    <= 1'b0;
         wb_rd_r    <= {RW{1'b0}};
         wb_data_r  <= {DW{1'b0}};
      end else if (flush) begin
         wb_valid_r <= 1'b0;
      end else if (accept_s) begin
         wb_valid_r <= 1'b1;
         wb_we_r    <= we_s;
         wb_rd_r    <= ex_rd;
         wb_data_r  <= data_s;
      end else if (wb_ready) begin
         wb_valid_r <= 1'b0;
      end
   end

   // Flag register; N follows the (possibly saturated) ALU result, V is recomputed from operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_r <= 3'b000;
      end else if (accept_s) begin
         if (set_z_s) begin
            flags_r[2] <= (ex_alu_out == {DW{1'b0}});
         end
         if (set_vn_s) begin
            flags_r[1] <= add_ovf(ex_in1, ex_in2, ex_opcode == OP_SUB);
            flags_r[0] <= ex_alu_out[DW-1];
         end
      end
   end

   // Branch resolution pulse and target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_taken_r  <= 1'b0;
         br_target_r <= {DW{1'b0}};
      end else begin
         br_taken_r <= take_s;
         if (take_s) begin
            br_target_r <= target_s;
         end
      end
   end

   // Run/halt state; only reset leaves HALTED.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RUN;
      end else if (accept_s && (ex_opcode == OP_HLT)) begin
         state_r <= ST_HALTED;
      end
   end

endmodule

// File: tb/tb_alu_result_commit.sv
// Directed bench for alu_result_commit: a table of single-op vectors applied back to back,
// then hand-written sequences for backpressure, flush, halt and asynchronous reset.
module tb_alu_result_commit;

   localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, XORO = 4'h2, RED = 4'h3, SLL = 4'h4,
                          SRA = 4'h5, ROR = 4'h6, PADDSB = 4'h7, LW = 4'h8, SW = 4'h9,
                          LLB = 4'hA, LHB = 4'hB, B = 4'hC, BR = 4'hD, PCS = 4'hE, HLT = 4'hF;

   typedef struct {
      logic [3:0]  op;
      logic [2:0]  cond;
      logic [8:0]  imm;
      logic [15:0] in1, in2, alu, pc2;
      logic        we;
      logic [15:0] data;
      logic [2:0]  fl;
      logic        bt;
      logic [15:0] tgt;
   } vec_t;

   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, ex_valid = 1'b0, wb_ready = 1'b1;
   logic        ex_ready, wb_valid, wb_we, br_taken, halted;
   logic [3:0]  ex_opcode = 4'h0, ex_rd = 4'h0, wb_rd;
   logic [2:0]  ex_cond = 3'b000, flags;
   logic [8:0]  ex_imm9 = 9'h000;
   logic [15:0] ex_in1 = 16'h0, ex_in2 = 16'h0, ex_alu_out = 16'h0, ex_pc_plus2 = 16'h0;
   logic [15:0] wb_data, br_target;

   int total = 0;
   int bad   = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   alu_result_commit #(.DW(16), .RW(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_cond(ex_cond),
      .ex_imm9(ex_imm9), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_alu_out(ex_alu_out),
      .ex_pc_plus2(ex_pc_plus2), .ex_rd(ex_rd),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .br_taken(br_taken), .br_target(br_target), .flags(flags), .halted(halted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add_vec(input logic [3:0] op, input logic [2:0] cond, input logic [8:0] imm,
                          input logic [15:0] in1, input logic [15:0] in2, input logic [15:0] alu,
                          input logic [15:0] pc2, input logic we, input logic [15:0] data,
                          input logic [2:0] fl, input logic bt, input logic [15:0] tgt);
      vec_t v;
      v.op = op; v.cond = cond; v.imm = imm; v.in1 = in1; v.in2 = in2; v.alu = alu;
      v.pc2 = pc2; v.we = we; v.data = data; v.fl = fl; v.bt = bt; v.tgt = tgt;
      vq.push_back(v);
   endtask

   task automatic offer(input logic [3:0] op, input logic [2:0] cond, input logic [8:0] imm,
                        input logic [15:0] in1, input logic [15:0] in2, input logic [15:0] alu,
                        input logic [15:0] pc2, input logic [3:0] rd);
      ex_opcode = op; ex_cond = cond; ex_imm9 = imm; ex_in1 = in1; ex_in2 = in2;
      ex_alu_out = alu; ex_pc_plus2 = pc2; ex_rd = rd; ex_valid = 1'b1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd0);
      chk({tag, ".wb_we"}, {31'd0, wb_we}, 32'd0);
      chk({tag, ".wb_rd"}, {28'd0, wb_rd}, 32'd0);
      chk({tag, ".wb_data"}, {16'd0, wb_data}, 32'd0);
      chk({tag, ".br_taken"}, {31'd0, br_taken}, 32'd0);
      chk({tag, ".br_target"}, {16'd0, br_target}, 32'd0);
      chk({tag, ".flags"}, {29'd0, flags}, 32'd0);
      chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
      chk({tag, ".ex_ready"}, {31'd0, ex_ready}, 32'd1);
   endtask

   initial begin
      // flags column is {Z,V,N} after the op; branches see the flags left by the row above
      add_vec(ADD, 3'd0, 9'h000, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 3'b010, 1'b0, 16'h0000);
      add_vec(SUB, 3'd0, 9'h000, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b100, 1'b0, 16'h0000);
      add_vec(B,   3'd1, 9'h1FE, 16'h0000, 16'h0000, 16'h1234, 16'h0010, 1'b0, 16'h1234, 3'b100, 1'b1, 16'h000C);
      add_vec(ADD, 3'd0, 9'h000, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1, 16'h8000, 3'b011, 1'b0, 16'h0000);
      add_vec(BR,  3'd6, 9'h000, 16'h4242, 16'h0000, 16'h1234, 16'h0000, 1'b0, 16'h1234, 3'b011, 1'b1, 16'h4242);
      add_vec(B,   3'd0, 9'h003, 16'h0000, 16'h0000, 16'h1234, 16'hFFFE, 1'b0, 16'h1234, 3'b011, 1'b1, 16'h0004);
      add_vec(LW,  3'd0, 9'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b011, 1'b0, 16'h0000);
      add_vec(RED, 3'd0, 9'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b011, 1'b0, 16'h0000);
      add_vec(PADDSB, 3'd0, 9'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b011, 1'b0, 16'h0000);
      add_vec(LLB, 3'd0, 9'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b011, 1'b0, 16'h0000);
      add_vec(SLL, 3'd0, 9'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b111, 1'b0, 16'h0000);
      add_vec(B,   3'd2, 9'h004, 16'h0000, 16'h0000, 16'h1234, 16'h0040, 1'b0, 16'h1234, 3'b111, 1'b0, 16'h0000);
      add_vec(PCS, 3'd0, 9'h000, 16'h0000, 16'h0000, 16'h5555, 16'h0ABC, 1'b1, 16'h0ABC, 3'b111, 1'b0, 16'h0000);
      add_vec(SW,  3'd0, 9'h000, 16'h0000, 16'h0000, 16'h2222, 16'h0000, 1'b0, 16'h2222, 3'b111, 1'b0, 16'h0000);
      add_vec(SUB, 3'd0, 9'h000, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b1, 16'h8000, 3'b011, 1'b0, 16'h0000);
      add_vec(XORO, 3'd0, 9'h000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 1'b1, 16'h8000, 3'b011, 1'b0, 16'h0000);
      add_vec(B,   3'd4, 9'h004, 16'h0000, 16'h0000, 16'h1234, 16'h0040, 1'b0, 16'h1234, 3'b011, 1'b0, 16'h0000);
      add_vec(B,   3'd5, 9'h0FF, 16'h0000, 16'h0000, 16'h1234, 16'h0100, 1'b0, 16'h1234, 3'b011, 1'b1, 16'h02FE);
      add_vec(SUB, 3'd0, 9'h000, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1'b1, 16'hFFFE, 3'b001, 1'b0, 16'h0000);
      add_vec(B,   3'd3, 9'h000, 16'h0000, 16'h0000, 16'h1234, 16'h0020, 1'b0, 16'h1234, 3'b001, 1'b1, 16'h0020);
      add_vec(B,   3'd7, 9'h100, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 1'b0, 16'h1234, 3'b001, 1'b1, 16'hFE00);
      add_vec(ADD, 3'd0, 9'h000, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 1'b1, 16'h0003, 3'b000, 1'b0, 16'h0000);
      add_vec(B,   3'd6, 9'h004, 16'h0000, 16'h0000, 16'h1234, 16'h0040, 1'b0, 16'h1234, 3'b000, 1'b0, 16'h0000);
      add_vec(ROR, 3'd0, 9'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b100, 1'b0, 16'h0000);
      add_vec(SRA, 3'd0, 9'h000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 1'b1, 16'h0001, 3'b000, 1'b0, 16'h0000);
      add_vec(LHB, 3'd0, 9'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b000, 1'b0, 16'h0000);
      add_vec(SUB, 3'd0, 9'h000, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 3'b010, 1'b0, 16'h0000);
      add_vec(BR,  3'd4, 9'h000, 16'hBEEF, 16'h0000, 16'h1234, 16'h0000, 1'b0, 16'h1234, 3'b010, 1'b1, 16'hBEEF);

      repeat (2) @(negedge clk);
      chk_reset("rst_held");
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset("rst_rel");

      // vectors issued back to back, each result checked one cycle after its accept
      for (int i = 0; i < vq.size(); i++) begin
         chk($sformatf("v%0d.ex_ready", i), {31'd0, ex_ready}, 32'd1);
         offer(vq[i].op, vq[i].cond, vq[i].imm, vq[i].in1, vq[i].in2, vq[i].alu, vq[i].pc2, i[3:0]);
         @(negedge clk);
         chk($sformatf("v%0d.wb_valid", i), {31'd0, wb_valid}, 32'd1);
         chk($sformatf("v%0d.wb_we", i), {31'd0, wb_we}, {31'd0, vq[i].we});
         chk($sformatf("v%0d.wb_rd", i), {28'd0, wb_rd}, {28'd0, i[3:0]});
         chk($sformatf("v%0d.wb_data", i), {16'd0, wb_data}, {16'd0, vq[i].data});
         chk($sformatf("v%0d.flags", i), {29'd0, flags}, {29'd0, vq[i].fl});
         chk($sformatf("v%0d.br_taken", i), {31'd0, br_taken}, {31'd0, vq[i].bt});
         if (vq[i].bt) chk($sformatf("v%0d.br_target", i), {16'd0, br_target}, {16'd0, vq[i].tgt});
      end
      ex_valid = 1'b0;
      @(negedge clk);
      chk("idle.wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("idle.br_taken", {31'd0, br_taken}, 32'd0);

      // backpressure: slot full and not consumed holds the XOR and blocks the ADD
      wb_ready = 1'b0;
      offer(XORO, 3'd0, 9'h000, 16'h0000, 16'h0000, 16'h00F0, 16'h0000, 4'd7);
      @(negedge clk);
      offer(ADD, 3'd0, 9'h000, 16'h0008, 16'h0009, 16'h0011, 16'h0000, 4'd8);
      for (int k = 0; k < 3; k++) begin
         chk("bp.wb_valid", {31'd0, wb_valid}, 32'd1);
         chk("bp.ex_ready", {31'd0, ex_ready}, 32'd0);
         chk("bp.wb_data", {16'd0, wb_data}, 32'h00F0);
         chk("bp.wb_rd", {28'd0, wb_rd}, 32'd7);
         chk("bp.flags", {29'd0, flags}, 32'b010);
         @(negedge clk);
      end
      wb_ready = 1'b1;
      #1 chk("bp.ready_same_cycle", {31'd0, ex_ready}, 32'd1);
      @(negedge clk);
      ex_valid = 1'b0;
      chk("bp.next_data", {16'd0, wb_data}, 32'h0011);
      chk("bp.next_rd", {28'd0, wb_rd}, 32'd8);
      chk("bp.next_flags", {29'd0, flags}, 32'b000);
      @(negedge clk);
      chk("bp.drained", {31'd0, wb_valid}, 32'd0);

      // flush: suppressed branch and suppressed flag update, slot emptied
      offer(SUB, 3'd0, 9'h000, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'd2);
      @(negedge clk);
      chk("fl.pre_flags", {29'd0, flags}, 32'b100);
      offer(BR, 3'd7, 9'h000, 16'h7777, 16'h0000, 16'h1234, 16'h0000, 4'd3);
      flush = 1'b1;
      @(negedge clk);
      chk("fl.br_taken", {31'd0, br_taken}, 32'd0);
      chk("fl.wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("fl.flags", {29'd0, flags}, 32'b100);
      offer(ADD, 3'd0, 9'h000, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 4'd4);
      @(negedge clk);
      chk("fl.add_flags", {29'd0, flags}, 32'b100);
      chk("fl.add_wb_valid", {31'd0, wb_valid}, 32'd0);
      flush = 1'b0;
      ex_valid = 1'b0;

      // halt: sticky, blocks intake, slot still drains
      wb_ready = 1'b0;
      offer(HLT, 3'd0, 9'h000, 16'h0000, 16'h0000, 16'h9999, 16'h0000, 4'd3);
      @(negedge clk);
      offer(ADD, 3'd0, 9'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'd5);
      chk("h.halted", {31'd0, halted}, 32'd1);
      chk("h.ex_ready", {31'd0, ex_ready}, 32'd0);
      chk("h.wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("h.wb_we", {31'd0, wb_we}, 32'd0);
      chk("h.wb_data", {16'd0, wb_data}, 32'h9999);
      wb_ready = 1'b1;
      @(negedge clk);
      chk("h.drained", {31'd0, wb_valid}, 32'd0);
      chk("h.still_halted", {31'd0, halted}, 32'd1);
      chk("h.ready_low", {31'd0, ex_ready}, 32'd0);
      @(negedge clk);
      chk("h.flags_kept", {29'd0, flags}, 32'b100);
      chk("h.no_accept", {31'd0, wb_valid}, 32'd0);
      ex_valid = 1'b0;

      // asynchronous reset out of HALTED
      #2 rst_n = 1'b0;
      #1 chk_reset("rst_halt");
      @(negedge clk);
      rst_n = 1'b1;

      // asynchronous reset while a branch pulse and a full slot are live
      wb_ready = 1'b0;
      offer(B, 3'd7, 9'h001, 16'h0000, 16'h0000, 16'h1234, 16'h0100, 4'd6);
      @(negedge clk);
      ex_valid = 1'b0;
      chk("ar.br_taken", {31'd0, br_taken}, 32'd1);
      chk("ar.br_target", {16'd0, br_target}, 32'h0102);
      chk("ar.wb_valid", {31'd0, wb_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_reset("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
